fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 110 +++++++++++
 tb/tb_fetch_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: issues one outstanding request at a time to instruction memory
// and queues returned {pc, instr} pairs in a 2-entry FIFO for the decode stage.
module fetch_buffer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        req,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        imem_valid_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ready_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] req_pc_q;
    logic [1:0]  count_q;
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [31:0] pc_mem    [2];
    logic [31:0] instr_mem [2];

    logic        fifo_valid;
    logic        pop;
    logic        rsp_keep;
    logic        push;
    logic        issue_state;
    logic [2:0]  occ;
    logic        handshake;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = &{1'b0, redirect_pc_in[1:0]};

    assign fifo_valid = (count_q != 2'd0);
    assign valid_out  = fifo_valid;
    assign pc_out     = fifo_valid ? pc_mem[rd_ptr_q]    : 32'h0000_0000;
    assign instr_out  = fifo_valid ? instr_mem[rd_ptr_q] : NOP_INSTR;

    assign pop         = fifo_valid && !stall_in && !redirect_in;
    assign rsp_keep    = (state_q == WAIT) && imem_rvalid_in;
    assign push        = rsp_keep && !redirect_in;
    assign issue_state = (state_q == IDLE) || rsp_keep;

    // Occupancy after this cycle's push/pop; a new request needs a slot reserved for its response.
    assign occ = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};

    // Gating with reset keeps the request low while reset is held, even though the FSM already reads IDLE.
    assign imem_valid_out = reset && !redirect_in && issue_state && (occ < 3'd2);
    assign imem_addr_out  = fetch_pc_q;
    assign handshake      = imem_valid_out && imem_ready_in;

    always_ff @(posedge req or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else if (redirect_in) begin
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fetch_pc_q <= {redirect_pc_in[31:2], 2'b00};
            // A response landing this cycle retires the outstanding request; otherwise it must be discarded later.
            if (state_q != IDLE) begin
                state_q <= imem_rvalid_in ? IDLE : DROP;
            end
        end else begin
            count_q <= occ[1:0];
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (handshake) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
                state_q    <= WAIT;
            end else if (imem_rvalid_in && (state_q != IDLE)) begin
                state_q <= IDLE;
            end
        end
    end

    // Payload storage carries no reset; count gates every read of it.
    always_ff @(posedge req) begin
        if (handshake) begin
            req_pc_q <= fetch_pc_q;
        end
        if (push) begin
            pc_mem[wr_ptr_q]    <= req_pc_q;
            instr_mem[wr_ptr_q] <= imem_rdata_in;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: scoreboard of expected {pc, instr} pops plus
// per-cycle checks of the memory request interface.
module tb_fetch_buffer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_in = 1'b0;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = 32'h0;
    logic        imem_valid_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;

    logic        auto_mode = 1'b1;
    logic        auto_rv = 1'b0;
    logic [31:0] auto_rd = 32'h0;
    logic        man_rv = 1'b0;
    logic [31:0] man_rd = 32'h0;
    logic        mready = 1'b1;

    int    checks = 0;
    int    errors = 0;
    item_t exp_q[$];

    always #5 clk = ~clk;

    fetch_buffer dut (
        .req            (clk),
        .reset          (reset),
        .stall_in       (stall_in),
        .redirect_in    (redirect_in),
        .redirect_pc_in (redirect_pc_in),
        .imem_valid_out (imem_valid_out),
        .imem_addr_out  (imem_addr_out),
        .imem_ready_in  (imem_ready_in),
        .imem_rvalid_in (imem_rvalid_in),
        .imem_rdata_in  (imem_rdata_in),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .valid_out      (valid_out)
    );

    // Zero-wait memory returning the address as data; it knows nothing about reset.
    always @(posedge clk) begin
        auto_rv <= imem_valid_out && imem_ready_in;
        auto_rd <= imem_addr_out;
    end

    assign imem_ready_in  = mready;
    assign imem_rvalid_in = auto_mode ? auto_rv : man_rv;
    assign imem_rdata_in  = auto_mode ? auto_rd : man_rd;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_item(input logic [31:0] pc, input logic [31:0] instr);
        item_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    // Compare the head against the scoreboard whenever decode takes it this cycle.
    task automatic consume();
        item_t e;
        if (valid_out && !stall_in && !redirect_in) begin
            check1("sb_has_entry", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check32("pop_pc", pc_out, e.pc);
                check32("pop_instr", instr_out, e.instr);
            end
        end
    endtask

    task automatic cyc(input logic stl, input logic rdr, input logic [31:0] rpc,
                       input logic rdy, input logic rv, input logic [31:0] rd);
        consume();
        @(negedge clk);
        stall_in       = stl;
        redirect_in    = rdr;
        redirect_pc_in = rpc;
        mready         = rdy;
        man_rv         = rv;
        man_rd         = rd;
        #1;
    endtask

    task automatic run();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic do_reset(input logic am);
        consume();
        check32("sb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset       = 1'b0;
        stall_in    = 1'b0;
        redirect_in = 1'b0;
        man_rv      = 1'b0;
        mready      = 1'b1;
        auto_mode   = am;
        #1;
        check1("rst_imem_valid", imem_valid_out, 1'b0);
        check1("rst_valid_out", valid_out, 1'b0);
        check32("rst_instr_nop", instr_out, 32'h0000_0013);
        check32("rst_pc_zero", pc_out, 32'h0);
        @(negedge clk);
        #1;
        check1("rst_hold_no_req", imem_valid_out, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release and streaming at one instruction per cycle.
        do_reset(1'b1);
        check1("t1_first_req", imem_valid_out, 1'b1);
        check32("t1_first_addr", imem_addr_out, 32'h0);
        check1("t1_c0_valid", valid_out, 1'b0);
        expect_item(32'h0, 32'h0);
        expect_item(32'h4, 32'h4);
        expect_item(32'h8, 32'h8);
        expect_item(32'hC, 32'hC);
        run();
        check1("t1_c1_valid", valid_out, 1'b0);
        check32("t1_c1_addr", imem_addr_out, 32'h4);
        run();
        check1("t1_c2_valid", valid_out, 1'b1);
        run();
        check1("t1_c3_valid", valid_out, 1'b1);
        run();
        check1("t1_c4_valid", valid_out, 1'b1);
        run();
        check1("t1_c5_valid", valid_out, 1'b1);

        // Stall with two entries buffered.
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) expect_item(32'(i * 4), 32'(i * 4));
        run();
        run();
        run();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            check1("t2_stall_no_req", imem_valid_out, 1'b0);
            check32("t2_stall_head_pc", pc_out, 32'h8);
            check1("t2_stall_valid", valid_out, 1'b1);
        end
        run();
        check32("t2_rel_head", pc_out, 32'h8);
        check1("t2_rel_req", imem_valid_out, 1'b1);
        check32("t2_rel_addr", imem_addr_out, 32'h10);
        run();
        check32("t2_b2b_head", pc_out, 32'hC);
        run();
        run();

        // Redirect while waiting: late response dropped.
        do_reset(1'b0);
        check32("t3_first_addr", imem_addr_out, 32'h0);
        expect_item(32'h100, 32'h0000_1234);
        cyc(1'b0, 1'b1, 32'h103, 1'b1, 1'b0, 32'h0);
        check1("t3_redir_no_req", imem_valid_out, 1'b0);
        run();
        check1("t3_drop_no_req", imem_valid_out, 1'b0);
        check32("t3_drop_addr", imem_addr_out, 32'h100);
        check1("t3_drop_empty", valid_out, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        check1("t3_late_no_req", imem_valid_out, 1'b0);
        run();
        check1("t3_refetch_req", imem_valid_out, 1'b1);
        check32("t3_refetch_addr", imem_addr_out, 32'h100);
        check1("t3_late_not_pushed", valid_out, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_1234);
        check1("t3_c5_empty", valid_out, 1'b0);
        check32("t3_next_addr", imem_addr_out, 32'h104);
        run();
        check1("t3_first_valid", valid_out, 1'b1);

        // Redirect coinciding with a response and a would-be pop.
        do_reset(1'b1);
        expect_item(32'h0, 32'h0);
        expect_item(32'h200, 32'h200);
        run();
        run();
        cyc(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        check32("t4_head_kept", pc_out, 32'h4);
        check1("t4_redir_no_req", imem_valid_out, 1'b0);
        run();
        check1("t4_flushed", valid_out, 1'b0);
        check1("t4_req", imem_valid_out, 1'b1);
        check32("t4_target", imem_addr_out, 32'h200);
        run();
        check1("t4_c5_empty", valid_out, 1'b0);
        run();
        check1("t4_target_valid", valid_out, 1'b1);

        // Address wrap at the top of the address space.
        do_reset(1'b1);
        expect_item(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        expect_item(32'h0, 32'h0);
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
        run();
        check1("t5_top_req", imem_valid_out, 1'b1);
        check32("t5_top_addr", imem_addr_out, 32'hFFFF_FFFC);
        check1("t5_empty", valid_out, 1'b0);
        run();
        check32("t5_wrap_addr", imem_addr_out, 32'h0);
        run();
        check32("t5_first_pc", pc_out, 32'hFFFF_FFFC);
        run();
        check32("t5_second_pc", pc_out, 32'h0);

        // Reset mid-WAIT; stray response after release is ignored.
        do_reset(1'b0);
        check32("t6_first_addr", imem_addr_out, 32'h0);
        run();
        consume();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check1("t6_rst_no_req", imem_valid_out, 1'b0);
        @(negedge clk);
        reset  = 1'b1;
        mready = 1'b0;
        man_rv = 1'b1;
        man_rd = 32'h0000_0BAD;
        #1;
        check1("t6_rel_req", imem_valid_out, 1'b1);
        check32("t6_rel_addr", imem_addr_out, 32'h0);
        expect_item(32'h0, 32'h0000_5555);
        run();
        check1("t6_stray_ignored", valid_out, 1'b0);
        check32("t6_addr_again", imem_addr_out, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_5555);
        check1("t6_c2_empty", valid_out, 1'b0);
        run();
        check1("t6_valid", valid_out, 1'b1);
        consume();
        check32("final_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
